// File: rtl/cut_bist_pkg.sv
// cut_bist_pkg: shared types and helpers for the cut_bist_ctrl BIST block.
//   - state_e       : controller FSM states
//   - PAT_W / RSP_W : pattern (netlist input) and response (netlist output) widths
//   - LFSR_TAPS     : feedback taps of the 14-bit pattern LFSR (bits 13,4,2,0)
//   - MISR_TAPS     : feedback taps of the 8-bit MISR (bits 7,5,4,3)
//   - lfsr_next()   : one LFSR step, shift left with XOR feedback into bit 0
//   - misr_next()   : one MISR step, same shift form, then XOR with the response
package cut_bist_pkg;

    localparam int PAT_W = 14;
    localparam int RSP_W = 8;

    localparam logic [PAT_W-1:0] LFSR_TAPS = 14'h2015;
    localparam logic [RSP_W-1:0] MISR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [PAT_W-1:0] lfsr_next(input logic [PAT_W-1:0] s);
        return {s[PAT_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [RSP_W-1:0] misr_next(input logic [RSP_W-1:0] s,
                                                   input logic [RSP_W-1:0] d);
        return {s[RSP_W-2:0], ^(s & MISR_TAPS)} ^ d;
    endfunction

endpackage

// File: rtl/cut_bist_ctrl_if.sv
// cut_bist_ctrl_if: signal bundle between the BIST controller and its host /
// netlist under test.
//   start     : run request (host -> ctrl)
//   rsp_in    : netlist-under-test outputs (netlist -> ctrl)
//   pat_out   : pattern driving the netlist-under-test inputs (ctrl -> netlist)
//   busy      : run in progress
//   done      : sticky run-complete flag
//   pass      : final signature matched the golden value (valid with done)
//   signature : current MISR contents
//   abort     : cancel a run in progress; only present when CUT_BIST_ABORT_EN is defined
// Modports: master = host/netlist side, slave = controller side.
interface cut_bist_ctrl_if;
    import cut_bist_pkg::*;

    logic             start;
    logic [PAT_W-1:0] pat_out;
    logic [RSP_W-1:0] rsp_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [RSP_W-1:0] signature;
`ifdef CUT_BIST_ABORT_EN
    logic             abort;

    modport master (output start, rsp_in, abort,
                    input  pat_out, busy, done, pass, signature);
    modport slave  (input  start, rsp_in, abort,
                    output pat_out, busy, done, pass, signature);
`else
    modport master (output start, rsp_in,
                    input  pat_out, busy, done, pass, signature);
    modport slave  (input  start, rsp_in,
                    output pat_out, busy, done, pass, signature);
`endif

endinterface

// File: rtl/cut_bist_misr.sv
// cut_bist_misr: 8-bit multiple-input signature register.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (wins over en)
//   en         : absorb din this edge
//   din        : registered response word
//   sig        : current MISR contents
//   sig_nxt    : value the MISR would take if absorbing din this edge
module cut_bist_misr
    import cut_bist_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [RSP_W-1:0] din,
    output logic [RSP_W-1:0] sig,
    output logic [RSP_W-1:0] sig_nxt
);

    logic [RSP_W-1:0] misr_q, misr_d;

    assign sig_nxt = misr_next(misr_q, din);
    assign sig     = misr_q;

    always_comb begin
        misr_d = misr_q;
        if (clr)
            misr_d = '0;
        else if (en)
            misr_d = sig_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            misr_q <= '0;
        else
            misr_q <= misr_d;
    end

endmodule

// File: rtl/cut_bist_ctrl.sv
// cut_bist_ctrl: BIST controller for a 14-in / 8-out combinational netlist.
// An LFSR applies NUM_PATTERNS patterns starting at LFSR_SEED; responses are
// registered once and compacted in a MISR; the final signature is compared
// against GOLDEN_SIG.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : cut_bist_ctrl_if.slave (start, rsp_in, pat_out, busy, done,
//                pass, signature, and abort when CUT_BIST_ABORT_EN is defined)
// Optional feature macro: CUT_BIST_ABORT_EN adds the abort input, which
// returns a run in RUN/FLUSH to IDLE while keeping the MISR for debug.
module cut_bist_ctrl
    import cut_bist_pkg::*;
#(
    parameter int unsigned      NUM_PATTERNS = 256,
    parameter logic [PAT_W-1:0] LFSR_SEED    = 14'h0001,
    parameter logic [RSP_W-1:0] GOLDEN_SIG   = 8'h00
)(
    input  logic            clk,
    input  logic            rst_n,
    cut_bist_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(NUM_PATTERNS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS);

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;     // LFSR state doubles as the output pattern register
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RSP_W-1:0] rsp_q;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             misr_clr, misr_en;
    logic [RSP_W-1:0] misr_sig, misr_nxt;
    logic             abort_req;

    always_comb begin
        abort_req = 1'b0;
`ifdef CUT_BIST_ABORT_EN
        abort_req = bus.abort;
`endif
    end

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        pass_d   = pass_q;
        misr_clr = 1'b0;
        misr_en  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d  = ST_RUN;
                    pat_d    = LFSR_SEED;
                    cnt_d    = '0;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    misr_clr = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort_req) begin
                    state_d = ST_IDLE;
                    pat_d   = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end else begin
                    // rsp_q lags the pattern by one cycle, so the first RUN
                    // cycle has nothing valid to absorb yet.
                    misr_en = (cnt_q != '0);
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_d == LAST_CNT) begin
                        state_d = ST_FLUSH;
                        pat_d   = '0;
                    end else begin
                        pat_d   = lfsr_next(pat_q);
                    end
                end
            end
            ST_FLUSH: begin
                pat_d = '0;
                if (abort_req) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end else begin
                    // Absorbs the response to the last pattern.
                    misr_en = 1'b1;
                    pass_d  = (misr_nxt == GOLDEN_SIG);
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pat_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            cnt_q   <= '0;
            rsp_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            rsp_q   <= bus.rsp_in;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    cut_bist_misr u_misr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (misr_clr),
        .en      (misr_en),
        .din     (rsp_q),
        .sig     (misr_sig),
        .sig_nxt (misr_nxt)
    );

    assign bus.pat_out   = pat_q;
    assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.signature = misr_sig;

endmodule

// File: tb/tb_cut_bist_ctrl.sv
// tb_cut_bist_ctrl: directed/random bench for cut_bist_ctrl.
// Four instances with different NUM_PATTERNS / GOLDEN_SIG run side by side;
// the netlist under test is emulated by a combinational function of pat_out
// whose shape is chosen per run with $urandom. Expected signatures come from
// a pattern-list / signature model built directly from the LFSR/MISR rules.
module tb_cut_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a, start_o;
    bit         mode;
    logic [7:0] key;
    int         nerr = 0;
    int         nchk = 0;

    always #5 clk = ~clk;

    cut_bist_ctrl_if if_a ();
    cut_bist_ctrl_if if_b ();
    cut_bist_ctrl_if if_c ();
    cut_bist_ctrl_if if_d ();

    function automatic logic [7:0] rsp_fn(input logic [13:0] p, input bit m, input logic [7:0] k);
        return m ? (p[7:0] ^ p[13:6] ^ k) : k;
    endfunction

    assign if_a.start  = start_a;
    assign if_b.start  = start_o;
    assign if_c.start  = start_o;
    assign if_d.start  = start_o;
    assign if_a.rsp_in = rsp_fn(if_a.pat_out, mode, key);
    assign if_b.rsp_in = rsp_fn(if_b.pat_out, mode, key);
    assign if_c.rsp_in = rsp_fn(if_c.pat_out, mode, key);
    assign if_d.rsp_in = rsp_fn(if_d.pat_out, mode, key);

`ifdef CUT_BIST_ABORT_EN
    logic abort_a;
    assign if_a.abort = abort_a;
    assign if_b.abort = 1'b0;
    assign if_c.abort = 1'b0;
    assign if_d.abort = 1'b0;
`endif

    cut_bist_ctrl #(.NUM_PATTERNS(4), .LFSR_SEED(14'h0001), .GOLDEN_SIG(8'h00))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    cut_bist_ctrl #(.NUM_PATTERNS(1), .LFSR_SEED(14'h0001), .GOLDEN_SIG(8'h01))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    cut_bist_ctrl #(.NUM_PATTERNS(2), .LFSR_SEED(14'h0001), .GOLDEN_SIG(8'h03))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
    cut_bist_ctrl #(.NUM_PATTERNS(4), .LFSR_SEED(14'h0001), .GOLDEN_SIG(8'h5A))
        dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

    // ---------------- reference model ----------------
    // Pattern list of a run from seed 1.
    function automatic logic [13:0] model_pat(input int k);
        logic [13:0] q[$];
        q.push_back(14'h0001);
        for (int i = 1; i <= k; i++) begin
            logic [13:0] p;
            p = q[i-1];
            q.push_back({p[12:0], p[13] ^ p[4] ^ p[2] ^ p[0]});
        end
        return q[k];
    endfunction

    // Signature after absorbing the responses to the first n patterns.
    function automatic logic [7:0] model_sig(input int n, input bit m, input logic [7:0] k);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < n; i++)
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ rsp_fn(model_pat(i), m, k);
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, "_pat"},  32'(if_a.pat_out), 32'd0);
        chk({tag, "_busy"}, 32'(if_a.busy),    32'd0);
        chk({tag, "_done"}, 32'(if_a.done),    32'd0);
        chk({tag, "_pass"}, 32'(if_a.pass),    32'd0);
    endtask

    // One run of every instance. Checks dut_a cycle by cycle, then all four
    // signatures / pass flags. mid_start >= 0 pulses start during RUN;
    // hold keeps start high through DONE to check back-to-back restart.
    task automatic run_all(input int mid_start, input bit hold);
        int n;
        logic [7:0] s;
        n = 4;
        start_a = 1'b1;
        start_o = 1'b1;
        for (int c = 0; c <= n + 1; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                start_o = 1'b0;
                if (!hold) start_a = 1'b0;
            end
            if (c == mid_start) start_a = 1'b1;
            if (mid_start >= 0 && c == mid_start + 1) start_a = 1'b0;
            chk("pat",  32'(if_a.pat_out), (c < n) ? 32'(model_pat(c)) : 32'd0);
            chk("busy", 32'(if_a.busy), 32'(c <= n));
            chk("done", 32'(if_a.done), 32'(c == n + 1));
            if (c <= n) chk("pass_clr", 32'(if_a.pass), 32'd0);
        end
        s = model_sig(4, mode, key);
        chk("sig_a",  32'(if_a.signature), 32'(s));
        chk("pass_a", 32'(if_a.pass),      32'(s == 8'h00));
        chk("sig_d",  32'(if_d.signature), 32'(s));
        chk("pass_d", 32'(if_d.pass),      32'(s == 8'h5A));
        chk("done_d", 32'(if_d.done),      32'd1);
        s = model_sig(1, mode, key);
        chk("sig_b",  32'(if_b.signature), 32'(s));
        chk("pass_b", 32'(if_b.pass),      32'(s == 8'h01));
        s = model_sig(2, mode, key);
        chk("sig_c",  32'(if_c.signature), 32'(s));
        chk("pass_c", 32'(if_c.pass),      32'(s == 8'h03));
        chk("done_c", 32'(if_c.done),      32'd1);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_o = 1'b0;
        mode    = 1'b0;
        key     = 8'h00;
`ifdef CUT_BIST_ABORT_EN
        abort_a = 1'b0;
`endif
        #3;
        chk_idle_a("rst");
        chk("rst_sig", 32'(if_a.signature), 32'd0);
        chk("rst_sig_b", 32'(if_b.signature), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Responses tied to 0, then to 1.
        run_all(-1, 1'b0);
        key = 8'h01;
        run_all(-1, 1'b0);

        // Random netlist functions, one with a start pulse mid-run.
        mode = 1'b1;
        key  = 8'($urandom);
        run_all(2, 1'b0);
        for (int r = 0; r < 4; r++) begin
            mode = 1'($urandom);
            key  = 8'($urandom);
            run_all(-1, 1'b0);
        end

        // start held through DONE: one DONE cycle, then a fresh run.
        mode = 1'b1;
        key  = 8'($urandom);
        run_all(-1, 1'b1);
        @(posedge clk); #1;
        chk("b2b_busy", 32'(if_a.busy),    32'd1);
        chk("b2b_pat",  32'(if_a.pat_out), 32'h0001);
        chk("b2b_done", 32'(if_a.done),    32'd0);
        start_a = 1'b0;
        for (int i = 0; i < 20 && !if_a.done; i++) begin
            @(posedge clk); #1;
        end
        chk("b2b_fin", 32'(if_a.done), 32'd1);
        chk("b2b_sig", 32'(if_a.signature), 32'(model_sig(4, mode, key)));

        // Asynchronous reset in RUN cycle 2, then a clean rerun.
        start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_busy", 32'(if_a.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_idle_a("arst");
        chk("arst_sig", 32'(if_a.signature), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        run_all(-1, 1'b0);

`ifdef CUT_BIST_ABORT_EN
        // Abort in RUN cycle 2: back to idle, MISR keeps one absorption.
        start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; abort_a = 1'b1;
        @(posedge clk); #1; abort_a = 1'b0;
        chk_idle_a("abort");
        chk("abort_sig", 32'(if_a.signature), 32'(model_sig(1, mode, key)));
        @(posedge clk); #1;
        chk("abort_stay", 32'(if_a.busy), 32'd0);
        run_all(-1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
